// File: rtl/beat_pkg.sv
// Shared constants for the beat recorder front end: note scan codes, their ASCII
// values, the break/extended prefix codes and the scan-code decoder state type.
package beat_pkg;

  localparam int ASCII_W = 7;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  localparam logic [7:0] SC_A = 8'h1C;
  localparam logic [7:0] SC_S = 8'h1B;
  localparam logic [7:0] SC_D = 8'h23;
  localparam logic [7:0] SC_F = 8'h2B;
  localparam logic [7:0] SC_G = 8'h34;
  localparam logic [7:0] SC_H = 8'h33;
  localparam logic [7:0] SC_J = 8'h3B;
  localparam logic [7:0] SC_K = 8'h42;

  localparam logic [ASCII_W-1:0] ASC_A = 7'h61;
  localparam logic [ASCII_W-1:0] ASC_S = 7'h73;
  localparam logic [ASCII_W-1:0] ASC_D = 7'h64;
  localparam logic [ASCII_W-1:0] ASC_F = 7'h66;
  localparam logic [ASCII_W-1:0] ASC_G = 7'h67;
  localparam logic [ASCII_W-1:0] ASC_H = 7'h68;
  localparam logic [ASCII_W-1:0] ASC_J = 7'h6A;
  localparam logic [ASCII_W-1:0] ASC_K = 7'h6B;

  typedef enum logic [1:0] {
    DEC_NORMAL,
    DEC_BREAK,
    DEC_EXT,
    DEC_EXT_BREAK
  } dec_state_e;

  // Zero means "not a note key"; callers rely on that to skip unmapped codes.
  function automatic logic [ASCII_W-1:0] note_ascii(input logic [7:0] code);
    case (code)
      SC_A:    return ASC_A;
      SC_S:    return ASC_S;
      SC_D:    return ASC_D;
      SC_F:    return ASC_F;
      SC_G:    return ASC_G;
      SC_H:    return ASC_H;
      SC_J:    return ASC_J;
      SC_K:    return ASC_K;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: input synchronisers, falling-edge detect, 11-bit frame FSM
// and inter-edge watchdog. Parity enforcement is enabled by PS2_PARITY_CHECK_EN.
module ps2_rx_frame #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       err
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  localparam logic [16:0] WD_LIMIT = 17'(TIMEOUT_CYCLES);

`ifdef PS2_PARITY_CHECK_EN
  localparam bit PARITY_CHECK = 1'b1;
`else
  localparam bit PARITY_CHECK = 1'b0;
`endif

  logic [SYNC_STAGES-1:0] clk_sync, data_sync;
  logic        clk_prev;
  logic        fall, data_s;
  logic [1:0]  state;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift;
  logic        par_bit;
  logic        parity_ok;
  logic [16:0] wd_cnt;

  // Synchronisers reset to the idle-high line level so reset never fakes an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev  <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign fall      = clk_prev & ~clk_sync[SYNC_STAGES-1];
  assign data_s    = data_sync[SYNC_STAGES-1];
  assign parity_ok = ^{shift, par_bit};

  // NOTE: sequential state uses non-blocking assignments only, so every branch
  // below reads the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      shift      <= '0;
      par_bit    <= 1'b0;
      wd_cnt     <= '0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
      err        <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      err        <= 1'b0;

      if (state == ST_IDLE || fall)  wd_cnt <= '0;
      else if (wd_cnt != WD_LIMIT)   wd_cnt <= wd_cnt + 17'd1;

      if (state != ST_IDLE && !fall && wd_cnt == WD_LIMIT) begin
        state <= ST_IDLE;
        err   <= 1'b1;
      end else if (fall) begin
        case (state)
          ST_IDLE: begin
            if (!data_s) begin
              state   <= ST_DATA;
              bit_cnt <= '0;
            end
          end
          ST_DATA: begin
            shift   <= {data_s, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= ST_PARITY;
          end
          ST_PARITY: begin
            par_bit <= data_s;
            state   <= ST_STOP;
          end
          default: begin
            state <= ST_IDLE;
            if (!data_s || (PARITY_CHECK && !parity_ok)) begin
              err <= 1'b1;
            end else begin
              byte_data  <= shift;
              byte_valid <= 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 note-key decoder: turns scan-code bytes into a held 7-bit ASCII level.
// Optional parity enforcement in the receiver is selected by PS2_PARITY_CHECK_EN.
module ps2_key_decoder
  import beat_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ps2_clk,
  input  logic               ps2_data,
  output logic [ASCII_W-1:0] ascii,
  output logic               key_valid,
  output logic               frame_err
);

  logic [7:0]         byte_data;
  logic               byte_valid;
  logic               rx_err;
  logic [ASCII_W-1:0] note;
  dec_state_e         dec_state;

  ps2_rx_frame #(
    .SYNC_STAGES   (SYNC_STAGES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .err       (rx_err)
  );

  assign note = note_ascii(byte_data);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_state <= DEC_NORMAL;
      ascii     <= '0;
      key_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      frame_err <= rx_err;
      if (byte_valid) begin
        case (dec_state)
          DEC_NORMAL: begin
            if (byte_data == SC_BREAK)   dec_state <= DEC_BREAK;
            else if (byte_data == SC_EXT) dec_state <= DEC_EXT;
            else if (note != '0 && note != ascii) begin
              ascii     <= note;
              key_valid <= 1'b1;
            end
          end
          DEC_BREAK: begin
            dec_state <= DEC_NORMAL;
            // Releasing a key other than the held one must not clear the level.
            if (note != '0 && note == ascii) begin
              ascii     <= '0;
              key_valid <= 1'b1;
            end
          end
          DEC_EXT: dec_state <= (byte_data == SC_BREAK) ? DEC_EXT_BREAK : DEC_NORMAL;
          default: dec_state <= DEC_NORMAL;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: directed scenarios plus random scan-code
// traffic, compared against a byte-level reference model of held-note behaviour.
module tb_ps2_key_decoder;

  localparam int SYNC = 2;
  localparam int TO   = 100;
  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic [6:0] ascii;
  logic       key_valid;
  logic       frame_err;

  ps2_key_decoder #(.SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TO)) dut (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .ascii    (ascii),
    .key_valid(key_valid),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int kv_cnt = 0;
  int fe_cnt = 0;
  int both_cnt = 0;

  always @(negedge clk) begin
    if (key_valid) kv_cnt++;
    if (frame_err) fe_cnt++;
    if (key_valid && frame_err) both_cnt++;
  end

`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: note table, held key, and pending prefix flags.
  byte unsigned sc_tab[8]  = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h3B, 8'h42};
  byte unsigned asc_tab[8] = '{8'h61, 8'h73, 8'h64, 8'h66, 8'h67, 8'h68, 8'h6A, 8'h6B};
  int  m_ascii = 0;
  bit  m_release = 0;
  bit  m_ext = 0;

  function automatic int lookup(input byte unsigned b);
    for (int i = 0; i < 8; i++) if (sc_tab[i] == b) return int'(asc_tab[i]);
    return 0;
  endfunction

  function automatic int model_byte(input byte unsigned b);
    int n = lookup(b);
    int changed = 0;
    if (m_ext) begin
      if (!m_release && b == 8'hF0) m_release = 1;
      else begin m_ext = 0; m_release = 0; end
    end else if (m_release) begin
      if (n != 0 && n == m_ascii) begin m_ascii = 0; changed = 1; end
      m_release = 0;
    end else if (b == 8'hF0) m_release = 1;
    else if (b == 8'hE0) m_ext = 1;
    else if (n != 0 && n != m_ascii) begin m_ascii = n; changed = 1; end
    return changed;
  endfunction

  task automatic ps2_bit(input logic v);
    ps2_data = v;
    repeat (HALF) @(posedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(posedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_bits(input logic [7:0] b, input bit bad_par, input int nbits);
    logic [10:0] fr;
    fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(fr[i]);
    ps2_data = 1'b1;
  endtask

  task automatic do_frame(input string tag, input logic [7:0] b, input bit bad_par);
    int kv0, fe0, exp_kv, exp_fe;
    kv0 = kv_cnt;
    fe0 = fe_cnt;
    send_bits(b, bad_par, 11);
    repeat (12) @(posedge clk);
    if (bad_par && PAR_EN) begin
      exp_kv = 0;
      exp_fe = 1;
    end else begin
      exp_kv = model_byte(b);
      exp_fe = 0;
    end
    #1;
    check({tag, ".ascii"}, int'(ascii), m_ascii);
    check({tag, ".kv"}, kv_cnt - kv0, exp_kv);
    check({tag, ".err"}, fe_cnt - fe0, exp_fe);
  endtask

  byte unsigned pool[12] = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h3B, 8'h42,
                             8'hF0, 8'hF0, 8'hE0, 8'h15};

  initial begin
    int kv0, fe0;
    rst = 1'b1;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("rst.ascii", int'(ascii), 0);
    check("rst.kv", int'(key_valid), 0);
    check("rst.err", int'(frame_err), 0);
    rst = 1'b0;
    repeat (4) @(posedge clk);

    // Press and release one key.
    do_frame("a_make", 8'h1C, 0);
    do_frame("a_brk", 8'hF0, 0);
    do_frame("a_rel", 8'h1C, 0);

    // Last pressed wins; releasing the older key leaves the newer one held.
    do_frame("lp_a", 8'h1C, 0);
    do_frame("lp_s", 8'h1B, 0);
    do_frame("lp_brk", 8'hF0, 0);
    do_frame("lp_rel_a", 8'h1C, 0);
    do_frame("lp_brk2", 8'hF0, 0);
    do_frame("lp_rel_s", 8'h1B, 0);

    // Typematic repeats.
    do_frame("rep1", 8'h1C, 0);
    do_frame("rep2", 8'h1C, 0);
    do_frame("rep3", 8'h1C, 0);
    do_frame("rep_brk", 8'hF0, 0);
    do_frame("rep_rel", 8'h1C, 0);

    // Extended code swallowed, unmapped code ignored.
    do_frame("ext_pfx", 8'hE0, 0);
    do_frame("ext_code", 8'h1C, 0);
    do_frame("unmapped", 8'h15, 0);

    // Bad parity.
    do_frame("bad_par", 8'h23, 1);

    // Truncated frame aborted by the watchdog; decoder keeps its state.
    kv0 = kv_cnt;
    fe0 = fe_cnt;
    send_bits(8'hA5, 0, 5);
    repeat (TO + 20) @(posedge clk);
    #1;
    check("wd.err", fe_cnt - fe0, 1);
    check("wd.kv", kv_cnt - kv0, 0);
    check("wd.ascii", int'(ascii), m_ascii);
    do_frame("wd_next", 8'h42, 0);

    // Reset in the middle of a frame while 'f' is held.
    do_frame("pre_rst", 8'h2B, 0);
    send_bits(8'h3C, 0, 4);
    rst = 1'b1;
    #1;
    check("mid_rst.ascii", int'(ascii), 0);
    check("mid_rst.kv", int'(key_valid), 0);
    check("mid_rst.err", int'(frame_err), 0);
    m_ascii = 0;
    m_release = 0;
    m_ext = 0;
    repeat (3) @(posedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    do_frame("post_rst", 8'h34, 0);

    // Random scan-code traffic.
    for (int i = 0; i < 40; i++) begin
      do_frame($sformatf("rnd%0d", i), 8'(pool[$urandom_range(0, 11)]),
               $urandom_range(0, 7) == 0);
    end

    check("kv_err_overlap", both_cnt, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Front-end stage of the beat recorder: receives raw PS/2 keyboard frames and presents the currently held note key as a 7-bit ASCII code. It runs on the system clock and feeds the recorder stage directly. The recorder compares `ascii` against its previous value on every `clk` edge, so `ascii` is a level that is held for as long as the key is down, and it is 0 when no note key is held.

## Interface
- `SYNC_STAGES`, 2: flip-flop depth of the `ps2_clk`/`ps2_data` synchronisers (≥2).
- `TIMEOUT_CYCLES`, 50000: `clk` cycles allowed between `ps2_clk` falling edges inside a frame before the frame is aborted.
- `clk` input 1: system clock; the only clock.
- `rst` input 1: asynchronous, active-high reset.
- `ps2_clk` input 1: raw PS/2 clock from the keyboard, asynchronous.
- `ps2_data` input 1: raw PS/2 data, asynchronous.
- `ascii` output 7: held note key in ASCII; 0 = none.
- `key_valid` output 1: one-cycle pulse whenever `ascii` changes value.
- `frame_err` output 1: one-cycle pulse on an aborted or malformed frame.

## Operation
- Both PS/2 inputs pass through `SYNC_STAGES` flops.
- A falling edge on `ps2_clk` is detected when the synchronised previous value is 1 and the current value is 0. `ps2_data` is sampled on that cycle.
- Frame format: start bit (0), 8 data bits LSB first, odd parity bit, stop bit (1).
- Receiver FSM states: IDLE → DATA (8 bits) → PARITY → STOP → IDLE.
  - In IDLE, a start bit sampled as 1 is ignored and the FSM stays in IDLE.
  - A stop bit sampled as 0 discards the byte and pulses `frame_err`.
- Decoder FSM states: NORMAL, BREAK (entered after 0xF0), EXT (entered after 0xE0), EXT_BREAK (entered after 0xE0 then 0xF0).
  - EXT and EXT_BREAK consume the next byte, ignore it, and return to NORMAL.
- Note map: 0x1C→'a', 0x1B→'s', 0x23→'d', 0x2B→'f', 0x34→'g', 0x33→'h', 0x3B→'j', 0x42→'k'. Every other code is ignored.
- Make code (NORMAL state, mapped key):
  - `ascii` takes the mapped value (last-pressed wins).
  - Typematic repeats of the same key leave `ascii` unchanged and produce no `key_valid` pulse.
- Break code (BREAK state, mapped key):
  - `ascii` clears to 0 only if the released key equals the current `ascii`.
  - Releasing a key that is not the current one has no effect.
- Watchdog: inside a frame, if the cycle counter reaches `TIMEOUT_CYCLES` with no falling edge, the receiver returns to IDLE and pulses `frame_err`. The decoder FSM state is kept.
- Reset, including mid-frame: `ascii`=0, `key_valid`=0, `frame_err`=0, both FSMs go to IDLE/NORMAL, counters clear.

## Timing
- All outputs are registered.
- `ascii` and `key_valid` update on the first `clk` edge after the cycle in which the stop-bit falling edge is detected.
- End-to-end latency from a raw `ps2_clk` falling edge to `ascii` is `SYNC_STAGES`+2 cycles.
- `frame_err` asserts on the same edge that `ascii`/`key_valid` would have updated, or on the watchdog expiry edge.
- `key_valid` and `frame_err` are never high together.
- The watchdog counter is 17 bits wide. It saturates at the limit and resets on every detected falling edge.

## Configuration
- `PS2_PARITY_CHECK_EN` defined:
  - A byte whose parity is not odd is discarded and `frame_err` pulses.
  - The decoder state is unchanged by that byte.
- `PS2_PARITY_CHECK_EN` undefined:
  - The parity bit is clocked in but ignored.
  - All framed bytes reach the decoder.

## Structure
- Package `beat_pkg` holds:
  - `ASCII_W`=7;
  - scan-code constants `SC_BREAK`=8'hF0 and `SC_EXT`=8'hE0;
  - the eight note scan codes with their ASCII values;
  - the decoder state enum.
- Sub-module `ps2_rx_frame` contains the synchronisers, edge detector, receiver FSM, parity check and watchdog. It outputs `byte_data[7:0]`, a `byte_valid` pulse and an `err` pulse.
- The top level contains the decoder FSM and the note map.

## Test plan
- Send frames 0x1C, then 0xF0, 0x1C → `ascii` goes 0x61 with a `key_valid` pulse, then returns to 0 with a second pulse.
- Send 0x1C, 0x1B, 0xF0 0x1C → `ascii` reads 0x61, then 0x73, and stays at 0x73.
- Send 0x1C three times (typematic) → exactly one `key_valid` pulse; `ascii`=0x61 throughout.
- Send 0xE0 0x1C, then 0x15 (unmapped) → `ascii` stays 0, with no `key_valid` and no `frame_err`.
- Send 0x23 with parity flipped:
  - with `PS2_PARITY_CHECK_EN`: one `frame_err` pulse and `ascii`=0;
  - without it: `ascii`=0x64.
- Stop `ps2_clk` after 4 data bits, then wait `TIMEOUT_CYCLES` → one `frame_err` pulse; a following clean 0x42 frame gives `ascii`=0x6B.
- Assert `rst` mid-frame while `ascii`=0x66 → `ascii`=0 immediately; the next clean frame decodes correctly.
